// File: rtl/mtr_drv.sv
// Motor drive: complementary, dead-time separated PWM pairs for the left/right H-bridges from signed speed.
// Latency: PWM outputs and prd_strt are registered, 1 clk after the counter compare; duty updates only at period wrap.
// Backpressure: none; speed inputs are sampled continuously and only the value present at cnt == 2047 is used.
// Optional feature macro: SLEW_LIMIT_EN (limits the duty change per PWM period to MAX_STEP).
module mtr_drv #(
    parameter logic [10:0] NONOVERLAP = 11'h020,
    parameter logic [10:0] MAX_STEP   = 11'h040
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] lft_spd,
    input  logic [10:0] rght_spd,
    output logic        lftPWM1,
    output logic        lftPWM2,
    output logic        rghtPWM1,
    output logic        rghtPWM2,
    output logic        prd_strt
);

    logic [10:0] cnt;
    logic [10:0] duty_l;
    logic [10:0] duty_r;
    logic [10:0] tgt_l;
    logic [10:0] tgt_r;
    logic [10:0] duty_l_nxt;
    logic [10:0] duty_r_nxt;
    logic        prd_end;
    logic        pwm1_l_nxt;
    logic        pwm2_l_nxt;
    logic        pwm1_r_nxt;
    logic        pwm2_r_nxt;

    // Last count of the period; duty is reloaded here so the new value applies from cnt == 0.
    assign prd_end = (cnt == 11'h7FF);

    // Signed speed to unsigned duty: inverting the MSB adds 1024.
    assign tgt_l = {~lft_spd[10], lft_spd[9:0]};
    assign tgt_r = {~rght_spd[10], rght_spd[9:0]};

`ifdef SLEW_LIMIT_EN
    // Move cur toward tgt by at most MAX_STEP; the branch keeps the difference non-negative,
    // so neither the subtraction nor the final add/subtract can wrap or overshoot.
    function automatic logic [10:0] slew_step(input logic [10:0] cur, input logic [10:0] tgt);
        logic [10:0] diff;
        logic [10:0] step;
        logic [10:0] res;
        if (tgt >= cur) begin
            diff = tgt - cur;
            step = (diff > MAX_STEP) ? MAX_STEP : diff;
            res  = cur + step;
        end else begin
            diff = cur - tgt;
            step = (diff > MAX_STEP) ? MAX_STEP : diff;
            res  = cur - step;
        end
        return res;
    endfunction

    // Rate-limited duty candidate for the next boundary.
    always_comb begin
        duty_l_nxt = slew_step(duty_l, tgt_l);
        duty_r_nxt = slew_step(duty_r, tgt_r);
    end
`else
    logic unused_max_step;
    assign unused_max_step = ^MAX_STEP;

    // Without rate limiting the target is taken directly at the boundary.
    always_comb begin
        duty_l_nxt = tgt_l;
        duty_r_nxt = tgt_r;
    end
`endif

    // High side: on after the leading dead-time, off once the count reaches duty.
    // Low side: on from duty + dead-time to the wrap; the 12-bit sum keeps it low all period when it exceeds 2047.
    always_comb begin
        pwm1_l_nxt = (cnt >= NONOVERLAP) && (cnt < duty_l);
        pwm1_r_nxt = (cnt >= NONOVERLAP) && (cnt < duty_r);
        pwm2_l_nxt = ({1'b0, cnt} >= ({1'b0, duty_l} + {1'b0, NONOVERLAP}));
        pwm2_r_nxt = ({1'b0, cnt} >= ({1'b0, duty_r} + {1'b0, NONOVERLAP}));
    end

    // Free-running period counter shared by both sides; wraps 2047 -> 0 naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 11'h000;
        end else begin
            cnt <= cnt + 11'h001;
        end
    end

    // Duty registers reload only at the period boundary so a period never sees a mid-period change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_l <= 11'h400;
            duty_r <= 11'h400;
        end else if (prd_end) begin
            duty_l <= duty_l_nxt;
            duty_r <= duty_r_nxt;
        end
    end

    // Registered bridge drives and the period-start strobe (aligned with cnt == 0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lftPWM1  <= 1'b0;
            lftPWM2  <= 1'b0;
            rghtPWM1 <= 1'b0;
            rghtPWM2 <= 1'b0;
            prd_strt <= 1'b0;
        end else begin
            lftPWM1  <= pwm1_l_nxt;
            lftPWM2  <= pwm2_l_nxt;
            rghtPWM1 <= pwm1_r_nxt;
            rghtPWM2 <= pwm2_r_nxt;
            prd_strt <= prd_end;
        end
    end

endmodule

// File: tb/tb_mtr_drv.sv
// Bench for mtr_drv: scoreboard of expected per-period duty, checked against measured PWM windows.
// Latency: each window is the 2048 samples ending with the prd_strt sample.
// Backpressure: n/a; stimulus changes speeds at chosen points within a period.
`timescale 1ns/1ps
module tb_mtr_drv;

    localparam int NO   = 32;
    localparam int STEP = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] lft_spd = 11'h000;
    logic [10:0] rght_spd = 11'h000;
    logic        lftPWM1;
    logic        lftPWM2;
    logic        rghtPWM1;
    logic        rghtPWM2;
    logic        prd_strt;

    always #5 clk = ~clk;

    mtr_drv dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .lft_spd  (lft_spd),
        .rght_spd (rght_spd),
        .lftPWM1  (lftPWM1),
        .lftPWM2  (lftPWM2),
        .rghtPWM1 (rghtPWM1),
        .rghtPWM2 (rghtPWM2),
        .prd_strt (prd_strt)
    );

    typedef struct {
        int dl;
        int dr;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad = 0;
    int   md_l = 1024;
    int   md_r = 1024;
    int   n_close = 0;

    // Window measurement state.
    int idx, c1l, c2l, c1r, c2r, ovl, ovr, f1l, f2l, f1r, f2r;

    task automatic chk_val(input string tag, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    function automatic int tgt_of(input logic [10:0] s);
        return int'($signed(s)) + 1024;
    endfunction

    function automatic int next_duty(input int cur, input int tgt);
`ifdef SLEW_LIMIT_EN
        if (tgt > cur) return (tgt - cur > STEP) ? cur + STEP : tgt;
        else           return (cur - tgt > STEP) ? cur - STEP : tgt;
`else
        return tgt + 0 * cur;
`endif
    endfunction

    function automatic int hi1(input int d);
        return (d > NO) ? d - NO : 0;
    endfunction

    function automatic int hi2(input int d);
        return (d + NO <= 2047) ? 2048 - d - NO : 0;
    endfunction

    task automatic push_reset_exp();
        exp_t e;
        md_l = 1024;
        md_r = 1024;
        e.dl = md_l;
        e.dr = md_r;
        sb_q.push_back(e);
    endtask

    // Expected duty for the period that starts after the next boundary.
    task automatic push_exp();
        exp_t e;
        md_l = next_duty(md_l, tgt_of(lft_spd));
        md_r = next_duty(md_r, tgt_of(rght_spd));
        e.dl = md_l;
        e.dr = md_r;
        sb_q.push_back(e);
    endtask

    task automatic clear_win();
        idx = 0; c1l = 0; c2l = 0; c1r = 0; c2r = 0; ovl = 0; ovr = 0;
        f1l = -1; f2l = -1; f1r = -1; f2r = -1;
    endtask

    task automatic close_win();
        exp_t e;
        chk_val("sb_empty", int'(sb_q.size() == 0), 0);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk_val("period_len", idx, 2047);
            chk_val("l_pwm1_hi", c1l, hi1(e.dl));
            chk_val("l_pwm2_hi", c2l, hi2(e.dl));
            chk_val("r_pwm1_hi", c1r, hi1(e.dr));
            chk_val("r_pwm2_hi", c2r, hi2(e.dr));
            chk_val("l_overlap", ovl, 0);
            chk_val("r_overlap", ovr, 0);
            if (hi1(e.dl) > 0) chk_val("l_pwm1_rise", f1l, NO);
            if (hi2(e.dl) > 0) chk_val("l_pwm2_rise", f2l, e.dl + NO);
            if (hi1(e.dr) > 0) chk_val("r_pwm1_rise", f1r, NO);
            if (hi2(e.dr) > 0) chk_val("r_pwm2_rise", f2r, e.dr + NO);
        end
        n_close++;
    endtask

    // Monitor: sample outputs on the falling edge; sample idx reflects the counter value it was computed from.
    initial begin
        clear_win();
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                clear_win();
            end else begin
                if (lftPWM1)  begin c1l++; if (f1l < 0) f1l = idx; end
                if (lftPWM2)  begin c2l++; if (f2l < 0) f2l = idx; end
                if (rghtPWM1) begin c1r++; if (f1r < 0) f1r = idx; end
                if (rghtPWM2) begin c2r++; if (f2r < 0) f2r = idx; end
                if (lftPWM1 && lftPWM2)   ovl++;
                if (rghtPWM1 && rghtPWM2) ovr++;
                if (prd_strt) begin
                    close_win();
                    clear_win();
                end else begin
                    idx++;
                end
            end
        end
    end

    task automatic wait_close();
        int start;
        start = n_close;
        for (int i = 0; i < 2200 && n_close == start; i++) @(posedge clk);
        chk_val("prd_strt_seen", int'(n_close != start), 1);
        if (n_close == start) begin
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    endtask

    task automatic step(input int l, input int r);
        wait_close();
        @(negedge clk);
        lft_spd  = 11'(l);
        rght_spd = 11'(r);
        push_exp();
    endtask

    task automatic chk_all_low(input string tag);
        chk_val({tag, "_lftPWM1"},  int'(lftPWM1),  0);
        chk_val({tag, "_lftPWM2"},  int'(lftPWM2),  0);
        chk_val({tag, "_rghtPWM1"}, int'(rghtPWM1), 0);
        chk_val({tag, "_rghtPWM2"}, int'(rghtPWM2), 0);
        chk_val({tag, "_prd_strt"}, int'(prd_strt), 0);
    endtask

    initial begin
        push_reset_exp();
        repeat (3) @(negedge clk);
        chk_all_low("rst");
        #1 rst_n = 1'b1;
        push_exp();

        // Zero speed, then opposite directions, then full-scale extremes.
        step(0, 0);
        step(0, 0);
        step(512, -512);
        step(512, -512);
        step(-1024, 1023);
        step(-1024, 1023);
        step(0, 0);

        // Speed change in mid-period must not touch the running period.
        wait_close();
        @(negedge clk);
        repeat (600) @(negedge clk);
        lft_spd  = 11'(512);
        rght_spd = 11'(512);
        push_exp();

        // Hold the step long enough for a rate-limited duty to settle and hold.
        for (int i = 0; i < 9; i++) step(512, 512);

        // Asynchronous reset in the middle of a high-side pulse.
        wait_close();
        @(negedge clk);
        repeat (900) @(negedge clk);
        chk_val("pre_rst_lftPWM1", int'(lftPWM1), int'(sb_q[0].dl > 901));
        #2 rst_n = 1'b0;
        #1 chk_all_low("async_rst");
        sb_q.delete();
        lft_spd  = 11'h000;
        rght_spd = 11'h000;
        push_reset_exp();
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        push_exp();
        step(0, 0);
        wait_close();
        wait_close();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
